// File: rtl/time_set_controller_if.sv
// Load handshake between the time-set controller (master) and the timekeeper (slave).
interface time_set_controller_if;
    logic [31:0] time_value;
    logic        load_valid;
    logic        load_ready;

    modport master (output time_value, output load_valid, input load_ready);
    modport slave  (input time_value, input load_valid, output load_ready);
endinterface

// File: rtl/time_set_controller.sv
// Manual MMDDhhmm entry: button-driven BCD digit editor with commit-time validation
// and valid/ready delivery of the new time to the timekeeper.
module time_set_controller #(
    parameter int ERR_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         edit_en,
    input  logic [4:0]                   push_switch,
    input  logic [31:0]                  cur_time,
    time_set_controller_if.master        ld,
    output logic                         set_time_mode,
    output logic [2:0]                   cursor,
    output logic                         error
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_EDIT  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;
    localparam int CW = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;

    logic [4:0]    btn_s1_q, btn_s2_q, btn_prev_q, btn_edge_q;
    logic          en_s1_q, en_s2_q;
    logic [2:0]    state_q, state_d;
    logic [31:0]   digits_q, digits_d;
    logic [2:0]    cursor_q, cursor_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;

    // Edge is registered so a raw rise acts three edges after it is first sampled.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            btn_prev_q <= '0;
            btn_edge_q <= '0;
            en_s1_q    <= 1'b0;
            en_s2_q    <= 1'b0;
        end else begin
            btn_s1_q   <= push_switch;
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
            btn_edge_q <= btn_s2_q & ~btn_prev_q;
            en_s1_q    <= edit_en;
            en_s2_q    <= en_s1_q;
        end
    end

    logic inc_e, dec_e, cmt_e, left_e, right_e;
    assign {right_e, left_e, cmt_e, dec_e, inc_e} = btn_edge_q;

    function automatic logic [3:0] digit_max(input logic [2:0] pos);
        case (pos)
            3'd0:    return 4'd1;
            3'd2:    return 4'd3;
            3'd4:    return 4'd2;
            3'd6:    return 4'd5;
            default: return 4'd9;
        endcase
    endfunction

    function automatic logic [7:0] bcd2bin(input logic [3:0] t, input logic [3:0] u);
        return {4'd0, t} * 8'd10 + {4'd0, u};
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] m);
        case (m)
            8'd2:                      return 8'd28;
            8'd4, 8'd6, 8'd9, 8'd11:   return 8'd30;
            default:                   return 8'd31;
        endcase
    endfunction

    // Digit 0 (month tens) sits in the top nibble, so offset = (7 - cursor) * 4.
    logic [4:0] off;
    logic [3:0] cur_dig, dig_max, new_dig;
    assign off     = {~cursor_q, 2'b00};
    assign cur_dig = digits_q[off +: 4];
    assign dig_max = digit_max(cursor_q);

    always_comb begin
        new_dig = cur_dig;
        if (inc_e && !dec_e)
            new_dig = (cur_dig >= dig_max) ? 4'd0 : cur_dig + 4'd1;
        else if (dec_e && !inc_e)
            new_dig = (cur_dig == 4'd0 || cur_dig > dig_max) ? dig_max : cur_dig - 4'd1;
    end

    logic [7:0] mon, day, hr, mnt;
    logic       units_ok, date_ok;
    assign mon      = bcd2bin(digits_q[31:28], digits_q[27:24]);
    assign day      = bcd2bin(digits_q[23:20], digits_q[19:16]);
    assign hr       = bcd2bin(digits_q[15:12], digits_q[11:8]);
    assign mnt      = bcd2bin(digits_q[7:4],   digits_q[3:0]);
    assign units_ok = (digits_q[27:24] <= 4'd9) && (digits_q[19:16] <= 4'd9) &&
                      (digits_q[11:8]  <= 4'd9) && (digits_q[3:0]   <= 4'd9);
    assign date_ok  = units_ok && (mon >= 8'd1) && (mon <= 8'd12) &&
                      (day >= 8'd1) && (day <= days_in_month(mon)) &&
                      (hr <= 8'd23) && (mnt <= 8'd59);

    always_comb begin
        state_d   = state_q;
        digits_d  = digits_q;
        cursor_d  = cursor_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            S_IDLE: if (en_s2_q) begin
                digits_d = cur_time;
                cursor_d = 3'd0;
                state_d  = S_EDIT;
            end
            S_EDIT: begin
                if (!en_s2_q)
                    state_d = S_IDLE;
                else if (cmt_e)
                    state_d = S_CHECK;
                else begin
                    digits_d[off +: 4] = new_dig;
                    if (right_e && !left_e)      cursor_d = cursor_q + 3'd1;
                    else if (left_e && !right_e) cursor_d = cursor_q - 3'd1;
                end
            end
            S_CHECK: begin
                if (date_ok)
                    state_d = S_LOAD;
                else begin
                    state_d   = S_ERROR;
                    err_cnt_d = CW'(ERR_CYCLES - 1);
                end
            end
            S_LOAD: if (ld.load_ready) state_d = en_s2_q ? S_EDIT : S_IDLE;
            S_ERROR: begin
                if (err_cnt_q == '0) state_d = en_s2_q ? S_EDIT : S_IDLE;
                else                 err_cnt_d = err_cnt_q - CW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state_q   <= S_IDLE;
            digits_q  <= 32'h0101_0000;
            cursor_q  <= 3'd0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            cursor_q  <= cursor_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ld.time_value = digits_q;
    assign ld.load_valid = (state_q == S_LOAD);
    assign set_time_mode = (state_q != S_IDLE);
    assign error         = (state_q == S_ERROR);
    assign cursor        = cursor_q;
endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: directed button sequences, loads checked through a scoreboard.
module tb_time_set_controller;
    logic        clk = 1'b0;
    logic        rstb, edit_en;
    logic [4:0]  push_switch;
    logic [31:0] cur_time;
    logic        set_time_mode, error;
    logic [2:0]  cursor;

    time_set_controller_if ld_if();

    time_set_controller #(.ERR_CYCLES(16)) dut (
        .clk           (clk),
        .rstb          (rstb),
        .edit_en       (edit_en),
        .push_switch   (push_switch),
        .cur_time      (cur_time),
        .ld            (ld_if),
        .set_time_mode (set_time_mode),
        .cursor        (cursor),
        .error         (error)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] B_INC = 5'd1, B_DEC = 5'd2, B_CMT = 5'd4, B_LEFT = 5'd8, B_RIGHT = 5'd16;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Transfers are judged just after the falling edge, on what the next rising edge will see.
    always @(negedge clk) begin
        #1;
        if (rstb === 1'b0 && ld_if.load_valid === 1'b1 && ld_if.load_ready === 1'b1) begin
            if (sb_q.size() == 0) chk("load_unexpected", 32'(ld_if.load_valid), 32'd0);
            else                  chk("load_data", ld_if.time_value, sb_q.pop_front());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [4:0] b);
        push_switch = b;
        cyc(1);
        push_switch = '0;
        cyc(4);
    endtask

    task automatic go_edit(input logic [31:0] v);
        edit_en = 1'b0;
        cyc(4);
        cur_time = v;
        edit_en  = 1'b1;
        cyc(3);
        chk("enter_mode", 32'(set_time_mode), 32'd1);
        chk("enter_value", ld_if.time_value, v);
        chk("enter_cursor", 32'(cursor), 32'd0);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (ld_if.load_valid !== 1'b1 && k < 20) begin cyc(1); k++; end
        if (k >= 20) chk("load_valid_timeout", 32'(ld_if.load_valid), 32'd1);
    endtask

    logic [31:0] bad_vals [3] = '{32'h0230_1200, 32'h1301_0000, 32'h0101_2400};

    initial begin
        int   cnt;
        logic seen_lv;
        rstb = 1'b1; edit_en = 1'b0; push_switch = '0; cur_time = '0; ld_if.load_ready = 1'b0;
        cyc(3);
        chk("rst_value", ld_if.time_value, 32'h0101_0000);
        chk("rst_valid", 32'(ld_if.load_valid), 32'd0);
        chk("rst_mode", 32'(set_time_mode), 32'd0);
        chk("rst_cursor", 32'(cursor), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        rstb = 1'b0;
        cyc(2);

        go_edit(32'h1231_2359);
        go_edit(32'h1231_2350);
        pulse(B_INC);            chk("inc_wrap", ld_if.time_value, 32'h0231_2350);
        pulse(B_LEFT);           chk("left_wrap", 32'(cursor), 32'd7);
        pulse(B_DEC);            chk("dec_wrap", ld_if.time_value, 32'h0231_2359);
        pulse(B_INC | B_DEC);    chk("incdec_none", ld_if.time_value, 32'h0231_2359);
        pulse(B_LEFT | B_RIGHT); chk("lr_none", 32'(cursor), 32'd7);
        pulse(B_RIGHT);          chk("right_wrap", 32'(cursor), 32'd0);
        pulse(B_INC | B_RIGHT);  chk("inc_then_move_val", ld_if.time_value, 32'h1231_2359);
                                 chk("inc_then_move_cur", 32'(cursor), 32'd1);
        pulse(B_DEC);            chk("dec_plain", ld_if.time_value, 32'h1131_2359);

        // Back-pressured load: ready low for five valid cycles, high on the sixth.
        go_edit(32'h0228_2359);
        sb_q.push_back(32'h0228_2359);
        ld_if.load_ready = 1'b0;
        pulse(B_CMT);
        wait_valid();
        cnt = 0;
        while (ld_if.load_valid === 1'b1 && cnt < 20) begin
            cnt++;
            if (cnt == 6) ld_if.load_ready = 1'b1;
            cyc(1);
        end
        ld_if.load_ready = 1'b0;
        chk("valid_cycles", 32'(cnt), 32'd6);
        chk("after_load_mode", 32'(set_time_mode), 32'd1);
        chk("sb_drained_1", 32'(sb_q.size()), 32'd0);

        foreach (bad_vals[i]) begin
            go_edit(bad_vals[i]);
            ld_if.load_ready = 1'b1;
            pulse(B_CMT);
            cnt = 0; seen_lv = 1'b0;
            while (error === 1'b1 && cnt < 40) begin
                cnt++;
                seen_lv |= ld_if.load_valid;
                cyc(1);
            end
            ld_if.load_ready = 1'b0;
            chk("err_cycles", 32'(cnt), 32'd16);
            chk("err_no_valid", 32'(seen_lv), 32'd0);
            chk("err_digits", ld_if.time_value, bad_vals[i]);
            chk("err_back_edit", 32'(set_time_mode), 32'd1);
        end

        go_edit(32'h1015_0930);
        sb_q.push_back(32'h1015_0930);
        ld_if.load_ready = 1'b1;
        pulse(B_CMT | B_RIGHT);
        cyc(3);
        ld_if.load_ready = 1'b0;
        chk("cmt_right_cursor", 32'(cursor), 32'd0);
        chk("sb_drained_2", 32'(sb_q.size()), 32'd0);
        chk("cmt_right_valid_low", 32'(ld_if.load_valid), 32'd0);

        go_edit(32'h0615_1030);
        sb_q.push_back(32'h0615_1030);
        pulse(B_CMT);
        wait_valid();
        edit_en = 1'b0;
        cyc(5);
        chk("no_abort_in_load", 32'(ld_if.load_valid), 32'd1);
        ld_if.load_ready = 1'b1;
        cyc(1);
        ld_if.load_ready = 1'b0;
        cyc(1);
        chk("load_to_idle", 32'(set_time_mode), 32'd0);
        chk("idle_valid_low", 32'(ld_if.load_valid), 32'd0);
        chk("idle_digits_kept", ld_if.time_value, 32'h0615_1030);
        chk("sb_drained_3", 32'(sb_q.size()), 32'd0);

        go_edit(32'h1225_0800);
        pulse(B_CMT);
        wait_valid();
        rstb = 1'b1;
        #1;
        chk("rst_load_valid", 32'(ld_if.load_valid), 32'd0);
        chk("rst_load_value", ld_if.time_value, 32'h0101_0000);
        chk("rst_load_mode", 32'(set_time_mode), 32'd0);
        @(negedge clk);
        rstb = 1'b0;
        cyc(1);
        chk("post_rst_idle", 32'(set_time_mode), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- Sequences manual time entry for the wall clock. Debounced push buttons move an edit cursor over eight BCD digits (MMDDhhmm) and increment or decrement the digit under the cursor with per-digit wrap.
- On commit, the block validates the whole date/time and delivers it to the running timekeeper through a valid/ready load handshake.
- Sits between the board switch inputs and the timekeeping counter.

Parameters:
- ERR_CYCLES, 16, number of cycles the error flag is held after a failed commit (must be >= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rstb  in  1  asynchronous reset, active-high: asserted = 1.
- edit_en  in  1  level; 1 requests edit mode (DIP switch).
- push_switch  in  5  raw buttons: [0] inc, [1] dec, [2] commit, [3] cursor left, [4] cursor right.
- cur_time  in  32  live time from the timekeeper, BCD {Mt,Mu,Dt,Du,ht,hu,mt,mu}.
- load_ready  in  1  timekeeper accepts time_value.
- time_value  out  32  BCD time presented for load; also shows the digits being edited.
- load_valid  out  1  time_value is valid for load.
- set_time_mode  out  1  high in every state except IDLE.
- cursor  out  3  selected digit: 0 = month tens … 7 = minute units.
- error  out  1  high while in ERROR.

Behaviour:
- Reset values:
  - digits = 32'h0101_0000, so time_value = 32'h0101_0000.
  - load_valid = 0, set_time_mode = 0, cursor = 0, error = 0, state = IDLE.
  - sync/edge registers = 0.
- Input conditioning:
  - push_switch and edit_en each pass through a 2-FF synchronizer. Button edge = sync & ~prev.
  - A raw rise sampled at edge N acts at edge N+3.
  - Buttons are treated as already debounced.
- Digit maxima by cursor position 0..7: 1, 9, 3, 9, 2, 9, 5, 9.
  - inc: max wraps to 0.
  - dec: 0 wraps to max.
  - Digit range only; cross-digit validity is checked at commit.
- Cursor:
  - right: 7 wraps to 0.
  - left: 0 wraps to 7.
- Same-cycle edge priority in EDIT:
  - commit overrides all other edges.
  - inc together with dec: no digit change.
  - left together with right: no cursor move.
  - inc/dec together with a move: the digit at the old cursor updates, then the cursor moves.
- State machine:
  - IDLE: on synced edit_en = 1, copy cur_time into the digits, set cursor = 0, go to EDIT.
  - EDIT: apply edges as above.
    - synced edit_en = 0 → IDLE (abort; digits kept, no load).
    - commit → CHECK.
  - CHECK: one cycle, registered validation of:
    - month 01–12;
    - day 01..days_in_month (31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31; no leap year);
    - hour 00–23;
    - minute 00–59.
    - Pass → LOAD. Fail → ERROR.
  - LOAD: load_valid = 1 and time_value frozen until a cycle where load_ready = 1.
    - That cycle is the transfer. load_valid drops on the next edge.
    - Next state is EDIT if synced edit_en = 1, else IDLE.
    - An edit_en fall during LOAD does not abort. Button edges are ignored.
  - ERROR: error = 1 for exactly ERR_CYCLES cycles, then EDIT (or IDLE if synced edit_en = 0).
    - Digits are unchanged. Button edges are ignored.
- load_ready is ignored outside LOAD. load_valid is never asserted outside LOAD.
- rstb assertion in any state returns all outputs to reset values immediately (async). An in-flight load is dropped.

Test Plan:
- Reset, then edit_en = 1 with cur_time = 32'h1231_2359 → set_time_mode = 1, time_value = 32'h1231_2359, cursor = 0, all within 3 cycles of edit_en rising.
- Cursor 0 at value 1, one inc → 0. Press left from cursor 0 → cursor = 7. At cursor 7 with digit 0, one dec → 9. Inc and dec edges in the same cycle → no change.
- Digits 0228_2359, commit, load_ready held 0 for 5 cycles then 1 → load_valid high for 6 cycles with time_value = 32'h0228_2359, then drops; state returns to EDIT.
- Digits 0230_1200, commit → CHECK rejects (Feb 30); error high exactly 16 cycles; no load_valid; digits unchanged. Repeat for 1301_0000 and 0101_2400.
- Commit and right edges in the same cycle → cursor unchanged, load proceeds. edit_en = 0 during LOAD → load completes, then IDLE.
- rstb pulsed during LOAD → load_valid = 0 and time_value = 32'h0101_0000 immediately; after release the state is IDLE.
